// File: rtl/byte_encode_pkg.sv
// Shared constants, FSM encoding and helper functions for the ByteEncode_d block.
package byte_encode_pkg;

    localparam int NCOEF  = 256;          // coefficients per polynomial
    localparam int LANES  = 4;            // coefficients per input beat
    localparam int LANE_W = 16;           // width of one input lane
    localparam int DMAX   = 12;           // max bits per coefficient
    localparam int WORD_W = 64;           // output word width
    localparam int ACC_W  = 112;          // accumulator width (63 + 48 worst case)
    localparam int CNT_W  = 7;            // width of acc_cnt / beat counter
    localparam int PACK_W = LANES * DMAX; // bits appended by one beat at most
    localparam int BEATS  = NCOEF / LANES;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Out-of-range widths (0 or above DMAX) fall back to the widest legal width.
    function automatic logic [3:0] legalise_d(input logic [3:0] l);
        return ((l == 4'd0) || (l > 4'd12)) ? 4'd12 : l;
    endfunction

    // Stream byte 0 sits in the low byte of the accumulator; it must leave in [63:56].
    function automatic logic [WORD_W-1:0] byte_swap(input logic [WORD_W-1:0] w);
        logic [WORD_W-1:0] r;
        r = '0;
        for (int m = 0; m < 8; m++) begin
            r[63-8*m -: 8] = w[8*m +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_encode_bit_packer.sv
// LSB-first bit accumulator: appends 4*d bits per beat and hands out 64-bit words.
module byte_encode_bit_packer
    import byte_encode_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [WORD_W-1:0]   coeffs,
    input  logic [3:0]          d,
    input  logic                append,
    input  logic                extract,
    output logic [CNT_W-1:0]    acc_cnt,
    output logic [WORD_W-1:0]   word
);

    logic [ACC_W-1:0]  acc_reg, acc_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [15:0]       mask;
    logic [PACK_W-1:0] lane_bits [LANES];
    logic [PACK_W-1:0] packed_bits;
    logic [ACC_W-1:0]  acc_base;
    logic [CNT_W-1:0]  cnt_base;

    assign mask = (16'd1 << d) - 16'd1;

    // Each lane keeps only its low d bits and lands at offset lane*d within the beat.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane_bits[gi] = PACK_W'(coeffs[LANE_W*gi +: LANE_W] & mask)
                                   << (6'(gi) * 6'(d));
        end
    endgenerate

    // Merge the lanes into one contiguous little-endian bit group.
    always_comb begin
        packed_bits = '0;
        for (int k = 0; k < LANES; k++) begin
            packed_bits = packed_bits | lane_bits[k];
        end
    end

    // Drop the extracted word first, then append the new bits at the shifted fill level.
    always_comb begin
        acc_base = extract ? (acc_reg >> WORD_W) : acc_reg;
        cnt_base = extract ? (cnt_reg - 7'd64) : cnt_reg;
        acc_next = acc_base;
        cnt_next = cnt_base;
        if (append) begin
            acc_next = acc_base | (ACC_W'(packed_bits) << cnt_base);
            cnt_next = cnt_base + {1'b0, d, 2'b00};
        end
    end

    // Accumulator and fill-level registers.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            acc_reg <= '0;
            cnt_reg <= '0;
        end else begin
            acc_reg <= acc_next;
            cnt_reg <= cnt_next;
        end
    end

    assign acc_cnt = cnt_reg;
    assign word    = byte_swap(acc_reg[WORD_W-1:0]);

endmodule

// File: rtl/byte_encode.sv
// ByteEncode_d: packs 256 d-bit coefficients into a stream of 4*d 64-bit words.
module byte_encode
    import byte_encode_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rstn,
    input  logic [WORD_W-1:0]   i_coeffs,
    input  logic                i_coeffs_valid,
    output logic                o_coeffs_ready,
    input  logic [3:0]          i_l,
    output logic [WORD_W-1:0]   o_obytes,
    output logic                o_obytes_valid,
    input  logic                i_obytes_ready,
    output logic                o_done
);

    state_t             state_reg, state_next;
    logic [3:0]         d_reg;
    logic [3:0]         d_eff;
    logic [CNT_W-1:0]   in_cnt_reg;
    logic [5:0]         out_cnt_reg;
    logic [WORD_W-1:0]  obytes_reg;
    logic               ovalid_reg;
    logic [CNT_W-1:0]   acc_cnt;
    logic [WORD_W-1:0]  acc_word;
    logic               beat_fire;
    logic               word_fire;
    logic               extract;
    logic               last_word;

    // The first beat of a frame is packed with the live i_l since d_reg is not loaded yet.
    assign d_eff     = (state_reg == ST_IDLE) ? legalise_d(i_l) : d_reg;
    assign beat_fire = i_coeffs_valid && o_coeffs_ready;
    assign word_fire = ovalid_reg && i_obytes_ready;
    assign extract   = (acc_cnt >= 7'd64) && (!ovalid_reg || i_obytes_ready);
    assign last_word = (out_cnt_reg == ({d_reg, 2'b00} - 6'd1));

    byte_encode_bit_packer u_packer (
        .i_clk   (i_clk),
        .i_rstn  (i_rstn),
        .coeffs  (i_coeffs),
        .d       (d_eff),
        .append  (beat_fire),
        .extract (extract),
        .acc_cnt (acc_cnt),
        .word    (acc_word)
    );

    // FSM state register.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM next-state logic: a frame ends when its last word leaves.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (beat_fire) state_next = ST_RUN;
            ST_RUN:  if (word_fire && last_word) state_next = ST_DONE;
            ST_DONE: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // FSM outputs; ready is also held low while reset is asserted.
    always_comb begin
        o_coeffs_ready = 1'b0;
        o_done         = 1'b0;
        case (state_reg)
            ST_IDLE: o_coeffs_ready = i_rstn;
            ST_RUN: begin
                o_coeffs_ready = (acc_cnt < 7'd64) && (in_cnt_reg < 7'(BEATS));
                o_done         = word_fire && last_word;
            end
            default: ;
        endcase
    end

    // Frame width and beat / word counters.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            d_reg       <= '0;
            in_cnt_reg  <= '0;
            out_cnt_reg <= '0;
        end else begin
            if (state_reg == ST_IDLE && beat_fire) begin
                d_reg <= legalise_d(i_l);
            end
            if (state_reg == ST_DONE) begin
                in_cnt_reg  <= '0;
                out_cnt_reg <= '0;
            end else begin
                if (beat_fire) in_cnt_reg <= in_cnt_reg + 7'd1;
                if (word_fire) out_cnt_reg <= out_cnt_reg + 6'd1;
            end
        end
    end

    // Output word register: refilled whenever it is empty or draining this cycle.
    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            obytes_reg <= '0;
            ovalid_reg <= 1'b0;
        end else if (extract) begin
            obytes_reg <= acc_word;
            ovalid_reg <= 1'b1;
        end else if (word_fire) begin
            ovalid_reg <= 1'b0;
        end
    end

    assign o_obytes       = obytes_reg;
    assign o_obytes_valid = ovalid_reg;

endmodule
